// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the single-port SRAM controller.
// Holds the run-state enum, the response record and the byte-enable expander.
package sram_ctrl_pkg;

    localparam int SRAM_BITS = 32;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [SRAM_BITS-1:0] rdata;
        logic                 we;
    } rsp_t;

    function automatic logic [SRAM_BITS-1:0] be_to_mask(input logic [SRAM_BITS/8-1:0] be);
        logic [SRAM_BITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SRAM_BITS / 8; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Response FIFO for sram_1rw_ctrl: DEPTH entries, head driven from storage flops,
// occupancy exported so the controller can hand out request credits.
module sram_ctrl_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rsp_t          push_data,
    input  logic          pop,
    output logic          head_valid,
    output rsp_t          head_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok  = pop & head_valid;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push & ((cnt != CW'(DEPTH)) | pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_valid = (cnt != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign count      = cnt;

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Initiator-side controller for the 1RW SRAM macro with credit-based response return.
// Define SRAM_CTRL_ZEROIZE_EN to clear the whole array after every reset before accepting traffic.
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 2048,
    parameter int ADDR_WIDTH = 11,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS/8-1:0]     req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_rdata,
    output logic                  rsp_we,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd,
    output logic                  init_done
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    if (BITS != SRAM_BITS || (BITS % 8) != 0 || (1 << ADDR_WIDTH) != WORD_DEPTH || RSP_DEPTH < 2)
    begin : g_bad_cfg
        $error("sram_1rw_ctrl: unsupported parameter combination");
    end

    logic                  init_done_q;
    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic                  inflight_q;
    logic                  inflight_we_q;
    logic                  accept;
    logic                  pop;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credits_used;
    logic [CW:0]           credit_limit;
    logic                  head_valid;
    rsp_t                  head_data;
    rsp_t                  push_data;

`ifdef SRAM_CTRL_ZEROIZE_EN
    state_t state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_addr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN:  init_done_q <= 1'b1;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign init_wr = (state_q == ST_INIT) & ~rst;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign init_wr     = 1'b0;
    assign init_addr_q = '0;
`endif

    assign init_done = init_done_q;

    // A response leaving this cycle frees its slot for a request accepted in the same cycle.
    assign pop          = head_valid & rsp_ready;
    assign credits_used = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign credit_limit = (CW+1)'(RSP_DEPTH) + (CW+1)'(pop);
    assign req_ready    = init_done_q & ~rst & (credits_used < credit_limit);
    assign accept       = req_valid & req_ready;

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wd    = '0;
        sram_wmask = '0;
        if (init_wr) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = init_addr_q;
            sram_wmask = '1;
        end else if (accept) begin
            sram_ce   = 1'b1;
            sram_we   = req_we;
            sram_addr = req_addr;
            if (req_we) begin
                sram_wd    = req_wdata;
                sram_wmask = be_to_mask(req_be);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q    <= 1'b0;
            inflight_we_q <= 1'b0;
        end else begin
            inflight_q    <= accept;
            inflight_we_q <= accept & req_we;
        end
    end

    always_comb begin
        push_data.we    = inflight_we_q;
        push_data.rdata = inflight_we_q ? '0 : sram_rd;
    end

    sram_ctrl_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign rsp_valid = head_valid;
    assign rsp_rdata = head_data.rdata;
    assign rsp_we    = head_data.we;

endmodule
